// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter with registered one-hot grant, done/drop release and hold timeout.
module bus_arbiter #(
  parameter int n = 2,
  parameter int N = 2**n,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic         grant_valid,
  output logic [n-1:0] grant_idx,
  output logic [N-1:0] grant,
  output logic         timeout_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]   state_q, state_d;
  logic [n-1:0] ptr_q, ptr_d, grant_idx_q, grant_idx_d, sel;
  logic         grant_valid_q, grant_valid_d, timeout_err_q, timeout_err_d;
  logic [N-1:0] grant_q, grant_d, rot;
  logic [7:0]   cnt_q, cnt_d;
  logic         found, hit_to, rel;
  // rot[i] is req[(ptr+i) mod N], so the first set bit is the round-robin winner
  always_comb begin
    rot = N'({req, req} >> ptr_q);
    found = 1'b0;
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sel = n'(int'(ptr_q) + i >= N ? int'(ptr_q) + i - N : int'(ptr_q) + i);
      end
    end
  end
  always_comb begin
    hit_to = cnt_q == 8'(TIMEOUT - 1);
    rel = state_q == BUSY && (done || !req[grant_idx_q] || hit_to);
    state_d = state_q;
    ptr_d = ptr_q;
    grant_idx_d = grant_idx_q;
    grant_valid_d = grant_valid_q;
    cnt_d = cnt_q;
    timeout_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = BUSY;
        grant_idx_d = sel;
        grant_valid_d = 1'b1;
        cnt_d = '0;
      end
    end else if (rel) begin
      state_d = IDLE;
      grant_idx_d = '0;
      grant_valid_d = 1'b0;
      ptr_d = grant_idx_q == n'(N - 1) ? '0 : grant_idx_q + 1'b1;
      // a done or dropped request in the timeout cycle counts as a normal release
      timeout_err_d = hit_to && !done && req[grant_idx_q];
    end else begin
      cnt_d = cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
    end
    grant_d = grant_valid_d ? N'(1) << grant_idx_d : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_idx_q <= '0;
      grant_valid_q <= 1'b0;
      grant_q <= '0;
      cnt_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign grant_valid = grant_valid_q;
  assign grant_idx = grant_idx_q;
  assign grant = grant_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter with N=4, TIMEOUT=8.
module tb_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic       grant_valid, timeout_err;
  logic [1:0] grant_idx;
  logic [3:0] grant;
  int         checks = 0;
  int         errors = 0;
  typedef struct {
    string      tag;
    logic       v;
    logic [1:0] idx;
    logic [3:0] g;
    logic       te;
  } exp_t;
  exp_t sb[$];
  bus_arbiter #(.n(2), .N(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .grant(grant), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s %s got %b expected %b", tag, name, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic rst, input logic [3:0] rq, input logic dn,
                      input logic ev, input logic [1:0] eidx, input logic ete);
    exp_t e;
    logic [3:0] one;
    exp_t o;
    one = 4'b0001;
    e.tag = tag;
    e.v = ev;
    e.idx = ev ? eidx : 2'd0;
    e.g = ev ? one << eidx : 4'b0000;
    e.te = ete;
    reset = rst;
    req = rq;
    done = dn;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk(o.tag, "grant_valid", {3'b0, grant_valid}, {3'b0, o.v});
    chk(o.tag, "grant_idx", {2'b0, grant_idx}, {2'b0, o.idx});
    chk(o.tag, "grant", grant, o.g);
    chk(o.tag, "timeout_err", {3'b0, timeout_err}, {3'b0, o.te});
  endtask
  initial begin
    step("rst", 1, 4'b0000, 0, 0, 0, 0);
    step("rst_prio", 1, 4'b1111, 1, 0, 0, 0);
    step("idle", 0, 4'b0000, 0, 0, 0, 0);
    step("done_idle", 0, 4'b0000, 1, 0, 0, 0);
    step("single", 0, 4'b0001, 0, 1, 0, 0);
    step("single_rel", 0, 4'b0001, 1, 0, 0, 0);
    step("idle2", 0, 4'b0000, 0, 0, 0, 0);
    step("rst2", 1, 4'b0000, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step("fair_grant", 0, 4'b1111, 0, 1, 2'(k % 4), 0);
      step("fair_gap", 0, 4'b1111, 1, 0, 0, 0);
    end
    step("grant2", 0, 4'b0100, 0, 1, 2, 0);
    step("hold_other", 0, 4'b1111, 0, 1, 2, 0);
    step("rel2", 0, 4'b1111, 1, 0, 0, 0);
    step("wrap", 0, 4'b0011, 0, 1, 0, 0);
    step("drop", 0, 4'b0000, 0, 0, 0, 0);
    step("to_grant", 0, 4'b0010, 0, 1, 1, 0);
    for (int k = 0; k < 7; k++) step("to_hold", 0, 4'b0010, 0, 1, 1, 0);
    step("to_rel", 0, 4'b0010, 0, 0, 0, 1);
    step("to_pulse_end", 0, 4'b0000, 0, 0, 0, 0);
    step("sim_grant", 0, 4'b0100, 0, 1, 2, 0);
    for (int k = 0; k < 7; k++) step("sim_hold", 0, 4'b0100, 0, 1, 2, 0);
    step("sim_done", 0, 4'b0100, 1, 0, 0, 0);
    step("sim_after", 0, 4'b0000, 0, 0, 0, 0);
    step("drop_grant", 0, 4'b1000, 0, 1, 3, 0);
    for (int k = 0; k < 7; k++) step("drop_hold", 0, 4'b1000, 0, 1, 3, 0);
    step("drop_to", 0, 4'b0000, 0, 0, 0, 0);
    step("drop_after", 0, 4'b0000, 0, 0, 0, 0);
    step("mid_grant", 0, 4'b0100, 0, 1, 2, 0);
    step("mid_rst", 1, 4'b0100, 0, 0, 0, 0);
    step("post_rst", 0, 4'b1111, 0, 1, 0, 0);
    step("post_rel", 0, 4'b1111, 1, 0, 0, 0);
    step("post_next", 0, 4'b1111, 0, 1, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter n, default 2, meaning the grant index width.
REQ-002 The block SHALL have parameter N, default 2**n, meaning the number of requesters.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of BUSY cycles per grant (legal range 2..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, N bits: one request bit per requester; bit k high means requester k wants the shared resource.
REQ-007 The block SHALL have port done, input, 1 bit: one-cycle release pulse from the current owner.
REQ-008 The block SHALL have port grant_valid, output, 1 bit: a grant is active.
REQ-009 The block SHALL have port grant_idx, output, n bits: the binary index of the current owner.
REQ-010 The block SHALL have port grant, output, N bits: one-hot decode of grant_idx, enabled by grant_valid; all zeros when grant_valid=0.
REQ-011 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and BUSY.
REQ-013 The block SHALL keep all outputs registered; grant SHALL equal the one-hot decode of grant_idx whenever grant_valid=1.
REQ-014 The block SHALL keep a round-robin pointer ptr (n bits).
REQ-015 In IDLE with req!=0 at an edge, the block SHALL select the first set req bit at or after ptr in ascending circular order, load grant_idx, set grant_valid=1, clear the hold counter, and enter BUSY on that same edge (1-cycle latency from req to grant).
REQ-016 In IDLE with req=0, the block SHALL stay in IDLE with outputs at zero.
REQ-017 In BUSY, the block SHALL hold grant_idx and grant constant; changes on non-owner req bits SHALL have no effect.
REQ-018 In BUSY, the block SHALL release when done=1, when req[grant_idx]=0, or when the hold counter equals TIMEOUT-1.
REQ-019 On release, the block SHALL clear grant_valid, grant and grant_idx at that edge, set ptr=(grant_idx+1) mod N (N-1 wraps to 0), and return to IDLE.
REQ-020 The block SHALL enforce a minimum of one IDLE cycle between consecutive grants.
REQ-021 The hold counter SHALL increment once per BUSY cycle and SHALL saturate (never wrap).
REQ-022 On a timeout release, timeout_err SHALL be 1 for exactly the cycle after the release edge.
REQ-023 When done=1 or the owner drops req in the same cycle the timeout is reached, the release SHALL be treated as normal and timeout_err SHALL stay 0.
REQ-024 A done pulse in IDLE SHALL be ignored.

Reset
REQ-025 While reset=1 at an edge, the block SHALL set state=IDLE, ptr=0, grant_valid=0, grant_idx=0, grant=0, counter=0 and timeout_err=0, with reset taking priority over all other inputs.
REQ-026 A reset asserted during BUSY SHALL drop the grant at that edge; the first grant after reset SHALL search from index 0.

Verification (N=4, TIMEOUT=8)
REQ-027 Single request: after reset, req=0001 -> next cycle grant=0001, grant_idx=0, grant_valid=1; done pulse -> next cycle grant=0000.
REQ-028 Fairness: req=1111 held, done pulsed each grant -> grant_idx sequence 0,1,2,3,0, with one IDLE cycle between grants.
REQ-029 Wrap: after a grant to idx 2 (ptr=3), req=0011 -> grant_idx=0.
REQ-030 Timeout: owner holds req, no done -> grant drops after 8 BUSY cycles, timeout_err high for 1 cycle, ptr advances.
REQ-031 Simultaneous events: done=1 in the 8th BUSY cycle -> release with timeout_err=0.
REQ-032 Reset mid-grant: reset during grant=0100 -> next edge all outputs zero; then req=1111 -> grant_idx=0.
